// File: rtl/pe_layer_sequencer.sv
// Layer sequencer for one PE: optional weight preload from memory, then windowed compute
// with in-flight credit limiting, drain of outstanding pixels and a one-cycle done pulse.
module pe_layer_sequencer #(
  parameter int OUT_WIDTH        = 4,
  parameter int OUT_HEIGHT       = 2,
  parameter int NUM_WEIGHT_WORDS = 6,
  parameter int WEIGHT_BASE_ADDR = 23,
  parameter int MAX_INFLIGHT     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        load_weights,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        w_rd_en,
  output logic [15:0] w_rd_addr,
  input  logic [15:0] w_rd_data,
  output logic        weight_wr_en,
  output logic [31:0] weight_wr_addr,
  output logic [15:0] weight_wr_data,
  input  logic        win_valid,
  output logic        win_ready,
  output logic        pe_i_valid,
  input  logic        pe_ack,
  input  logic        pe_o_valid,
  input  logic        out_ready
);

  localparam int TOTAL = OUT_WIDTH * OUT_HEIGHT;
  localparam int CW    = $clog2(TOTAL + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_COMPUTE = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] issued_q, issued_d;
  logic [CW-1:0] completed_q, completed_d;
  logic [7:0]    inflight_q, inflight_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          w_rd_en_q, w_rd_en_d;
  logic [15:0]   w_rd_addr_q, w_rd_addr_d;
  logic          weight_wr_en_q, weight_wr_en_d;
  logic [31:0]   weight_wr_addr_q, weight_wr_addr_d;

  logic accept;
  logic cpl_ok;
  logic spurious;
  logic start_load;

  assign start_load = (state_q == S_IDLE) && start && load_weights;

  // Issue gate: window present, downstream room, credit available, layer not fully issued.
  assign pe_i_valid = (state_q == S_COMPUTE) && win_valid && out_ready &&
                      (inflight_q < 8'(MAX_INFLIGHT)) && (issued_q < CW'(TOTAL));
  assign accept     = pe_i_valid && pe_ack;
  assign win_ready  = accept;
  assign cpl_ok     = pe_o_valid && (inflight_q != 8'd0);
  assign spurious   = pe_o_valid && (inflight_q == 8'd0);

  always_comb begin
    issued_d    = issued_q + CW'(accept);
    completed_d = completed_q + CW'(cpl_ok);
    inflight_d  = inflight_q;
    if (accept && !cpl_ok) begin
      inflight_d = inflight_q + 8'd1;
    end else if (!accept && cpl_ok) begin
      inflight_d = inflight_q - 8'd1;
    end
    if (state_q == S_DONE) begin
      issued_d    = '0;
      completed_d = '0;
      inflight_d  = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = load_weights ? S_LOAD : S_COMPUTE;
      S_LOAD:    if (weight_wr_en_q && !w_rd_en_q) state_d = S_COMPUTE;
      S_COMPUTE: if (issued_q == CW'(TOTAL)) state_d = S_DRAIN;
      S_DRAIN:   if (completed_d == CW'(TOTAL)) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Weight reads run back-to-back; each write mirrors the previous cycle's read.
  always_comb begin
    w_rd_en_d   = w_rd_en_q;
    w_rd_addr_d = w_rd_addr_q;
    if (start_load) begin
      w_rd_en_d   = 1'b1;
      w_rd_addr_d = '0;
    end else if (w_rd_en_q) begin
      if (w_rd_addr_q == 16'(NUM_WEIGHT_WORDS - 1)) begin
        w_rd_en_d = 1'b0;
      end else begin
        w_rd_addr_d = w_rd_addr_q + 16'd1;
      end
    end
    weight_wr_en_d   = w_rd_en_q;
    weight_wr_addr_d = w_rd_en_q ? (32'(WEIGHT_BASE_ADDR) + {16'd0, w_rd_addr_q})
                                 : weight_wr_addr_q;
  end

  assign busy_d = (state_d != S_IDLE);
  assign done_d = (state_d == S_DONE);
  assign err_d  = err_q || spurious;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      issued_q         <= '0;
      completed_q      <= '0;
      inflight_q       <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      err_q            <= 1'b0;
      w_rd_en_q        <= 1'b0;
      w_rd_addr_q      <= '0;
      weight_wr_en_q   <= 1'b0;
      weight_wr_addr_q <= '0;
    end else begin
      state_q          <= state_d;
      issued_q         <= issued_d;
      completed_q      <= completed_d;
      inflight_q       <= inflight_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      err_q            <= err_d;
      w_rd_en_q        <= w_rd_en_d;
      w_rd_addr_q      <= w_rd_addr_d;
      weight_wr_en_q   <= weight_wr_en_d;
      weight_wr_addr_q <= weight_wr_addr_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign w_rd_en        = w_rd_en_q;
  assign w_rd_addr      = w_rd_addr_q;
  assign weight_wr_en   = weight_wr_en_q;
  assign weight_wr_addr = weight_wr_addr_q;
  // Read data arrives in the write cycle itself, so it is forwarded under the registered strobe.
  assign weight_wr_data = weight_wr_en_q ? w_rd_data : 16'd0;

endmodule

// File: tb/tb_pe_layer_sequencer.sv
// Randomized bench for pe_layer_sequencer with a queue-based PE/layer reference model.
module tb_pe_layer_sequencer;
  localparam int NW    = 6;
  localparam int BASE  = 23;
  localparam int MAXF  = 4;
  localparam int TOTAL = 8;

  logic        clk = 1'b0;
  logic        rst_n, start, load_weights, busy, done, err;
  logic        w_rd_en, weight_wr_en;
  logic [15:0] w_rd_addr, w_rd_data, weight_wr_data;
  logic [31:0] weight_wr_addr;
  logic        win_valid, win_ready, pe_i_valid, pe_ack, pe_o_valid, out_ready;

  always #5 clk = ~clk;

  pe_layer_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_weights(load_weights),
    .busy(busy), .done(done), .err(err),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
    .weight_wr_en(weight_wr_en), .weight_wr_addr(weight_wr_addr), .weight_wr_data(weight_wr_data),
    .win_valid(win_valid), .win_ready(win_ready), .pe_i_valid(pe_i_valid),
    .pe_ack(pe_ack), .pe_o_valid(pe_o_valid), .out_ready(out_ready)
  );

  int          n_chk  = 0;
  int          n_pass = 0;
  bit          err_exp = 1'b0;
  bit          mem_en = 1'b0;
  logic [15:0] mem_addr = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Memory returns word k = 0x100+k one cycle after the read strobe.
  task automatic tick();
    @(posedge clk);
    #1;
    w_rd_data = mem_en ? (16'h100 + mem_addr) : 16'hBEEF;
  endtask

  task automatic settle();
    #2;
    mem_en   = w_rd_en;
    mem_addr = w_rd_addr;
  endtask

  task automatic idle_inputs();
    start = 1'b0; load_weights = 1'b0; win_valid = 1'b0;
    pe_ack = 1'b0; pe_o_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic run_layer(input bit load, input bit rnd, input int lat, input int hold,
                           input int gap_at, input int gap_len);
    int issued = 0, completed = 0, inflight = 0;
    int la = -1, lc = -1, dcyc = -1, obs_acc = 0, done_cnt = 0;
    int due[$];
    bit exp_piv, ov;
    tick();
    idle_inputs();
    rst_n = 1'b1;
    start = 1'b1; load_weights = load; win_valid = 1'b1; out_ready = 1'b1; pe_ack = 1'b1;
    settle();
    chk("idle_busy", 32'(busy), 0);
    chk("idle_piv", 32'(pe_i_valid), 0);
    chk("err", 32'(err), 32'(err_exp));
    if (load) begin
      for (int c = 0; c <= NW; c++) begin
        tick();
        start = 1'($urandom); load_weights = 1'($urandom);
        win_valid = 1'b1; out_ready = 1'b1; pe_ack = 1'($urandom); pe_o_valid = 1'b0;
        settle();
        chk("rd_en", 32'(w_rd_en), (c < NW) ? 1 : 0);
        if (c < NW) chk("rd_addr", 32'(w_rd_addr), c);
        chk("wr_en", 32'(weight_wr_en), (c >= 1) ? 1 : 0);
        if (c >= 1) begin
          chk("wr_addr", weight_wr_addr, BASE + c - 1);
          chk("wr_data", 32'(weight_wr_data), 'h100 + c - 1);
        end
        chk("load_piv", 32'(pe_i_valid), 0);
        chk("load_busy", 32'(busy), 1);
        chk("err", 32'(err), 32'(err_exp));
      end
    end
    for (int c = 0; c < 400; c++) begin
      tick();
      start = 1'b0; load_weights = 1'b0;
      win_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (c >= gap_at && c < gap_at + gap_len) out_ready = 1'b0;
      pe_ack = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      ov = (c >= hold) && (due.size() > 0) && (due[0] <= c);
      pe_o_valid = ov;
      settle();
      exp_piv = win_valid && out_ready && (inflight < MAXF) && (issued < TOTAL);
      chk("pe_i_valid", 32'(pe_i_valid), 32'(exp_piv));
      chk("win_ready", 32'(win_ready), 32'(exp_piv && pe_ack));
      chk("done", 32'(done), (c == dcyc) ? 1 : 0);
      chk("busy", 32'(busy), 1);
      chk("err", 32'(err), 32'(err_exp));
      if (!rnd && hold > 0 && c == hold) chk("bp_accepts", obs_acc, MAXF);
      if (win_ready) obs_acc++;
      if (done) done_cnt++;
      if (exp_piv && pe_ack) begin
        issued++; inflight++;
        due.push_back(c + ((lat > 0) ? lat : int'($urandom_range(1, 5))));
        if (issued == TOTAL) la = c;
      end
      if (ov) begin
        void'(due.pop_front());
        completed++; inflight--;
        if (completed == TOTAL) lc = c;
      end
      // Drain begins two cycles after the last accept; done follows the later of that and the last completion.
      if (la >= 0 && lc >= 0 && dcyc < 0) dcyc = ((la + 2 > lc) ? la + 2 : lc) + 1;
      if (c == dcyc) break;
    end
    chk("done_pulses", done_cnt, 1);
    chk("accepts", obs_acc, TOTAL);
    tick();
    idle_inputs();
    settle();
    chk("post_busy", 32'(busy), 0);
    chk("post_done", 32'(done), 0);
    chk("post_piv", 32'(pe_i_valid), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    win_valid = 1'b1; out_ready = 1'b1; pe_ack = 1'b1;
    w_rd_data = '0;
    #3;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rd_en", 32'(w_rd_en), 0);
    chk("rst_rd_addr", 32'(w_rd_addr), 0);
    chk("rst_wr_en", 32'(weight_wr_en), 0);
    chk("rst_wr_addr", weight_wr_addr, 0);
    chk("rst_piv", 32'(pe_i_valid), 0);
    chk("rst_win_ready", 32'(win_ready), 0);

    run_layer(1'b1, 1'b0, 3, 0, -1, 0);
    run_layer(1'b0, 1'b0, 3, 0, -1, 0);
    run_layer(1'b0, 1'b0, 2, 8, -1, 0);
    run_layer(1'b0, 1'b0, 4, 0, 2, 5);

    tick();
    idle_inputs();
    pe_o_valid = 1'b1;
    settle();
    chk("spur_err_pre", 32'(err), 32'(err_exp));
    err_exp = 1'b1;
    tick();
    pe_o_valid = 1'b0;
    settle();
    chk("spur_err", 32'(err), 1);
    chk("spur_busy", 32'(busy), 0);
    run_layer(1'b0, 1'b0, 3, 6, -1, 0);

    for (int i = 0; i < 6; i++) begin
      run_layer(1'($urandom), 1'b1, 0, int'($urandom_range(0, 10)),
                int'($urandom_range(0, 8)), int'($urandom_range(0, 5)));
    end

    tick();
    idle_inputs();
    start = 1'b1; load_weights = 1'b1;
    settle();
    for (int c = 0; c <= 3; c++) begin
      tick();
      start = 1'b0; load_weights = 1'b0;
      win_valid = 1'b1; out_ready = 1'b1; pe_ack = 1'b1;
      settle();
      chk("mid_rd_addr", 32'(w_rd_addr), c);
    end
    rst_n = 1'b0;
    #1;
    err_exp = 1'b0;
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_err", 32'(err), 0);
    chk("mrst_rd_en", 32'(w_rd_en), 0);
    chk("mrst_rd_addr", 32'(w_rd_addr), 0);
    chk("mrst_wr_en", 32'(weight_wr_en), 0);
    chk("mrst_wr_addr", weight_wr_addr, 0);
    chk("mrst_wr_data", 32'(weight_wr_data), 0);
    chk("mrst_piv", 32'(pe_i_valid), 0);
    tick();
    tick();
    run_layer(1'b1, 1'b1, 0, 0, -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
